dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the requester ports, for N in {0 (CPU MEM stage), 1 (memcpy engine)}:
- rN_req, input, 1: access request.
- rN_we, input, 1: 1 = store, 0 = load.
- rN_funct3, input, 3: RV32I width code.
- rN_addr, input, 32: byte address.
- rN_wdata, input, 32: store data, right-aligned.
REQ-004 The module SHALL have the requester response ports, for N in {0, 1}:
- rN_gnt, output, 1: request accepted (one-cycle pulse).
- rN_rvalid, output, 1: access complete (one-cycle pulse).
- rN_rdata, output, 32: extended load data.
- rN_err, output, 1: misaligned or illegal access; qualified by rN_rvalid.
REQ-005 The module SHALL have the memory-side ports:
- mem_en, output, 1: access strobe.
- mem_we, output, 1: write.
- mem_be, output, 4: byte enables.
- mem_addr, output, 32: word address, bits [1:0] = 0.
- mem_wdata, output, 32: lane-steered write data.
- mem_rdata, input, 32: read word.
- mem_ready, input, 1: access done this cycle; mem_rdata is valid in the same cycle.

Function
REQ-006 The block SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, with one access outstanding at most.
REQ-007 In IDLE with at least one req high, the block SHALL pulse gnt to exactly one winner, latch that winner's we/funct3/addr/wdata and owner ID, and move to ACCESS.
REQ-008 A requester SHALL hold req and its fields stable until it sees gnt; req seen in any state other than IDLE SHALL be ignored.
REQ-009 In ACCESS, mem_en SHALL be 1 with mem_we/mem_be/mem_addr/mem_wdata driven from the latched fields until mem_ready=1; the cycle in which mem_ready=1 SHALL move the FSM to RESP and register the extended mem_rdata.
REQ-010 In RESP, the owner's rvalid SHALL pulse for one cycle (loads and stores alike), with rdata for loads and 0 for stores; the FSM SHALL then return to IDLE.
REQ-011 The minimum latency SHALL be gnt at cycle 0, mem_en at cycle 1, rvalid at cycle 2; each wait-state cycle (mem_ready=0) SHALL add one cycle.
REQ-012 mem_be SHALL be generated as follows:
- byte (000/100): 4'b0001 shifted left by addr[1:0].
- half (001/101): 4'b0011 shifted left by 2*addr[1].
- word (010): 4'b1111.
REQ-013 mem_wdata SHALL replicate the byte/half across lanes: {4{b}} for byte, {2{h}} for half, the word as-is.
REQ-014 Load extraction SHALL select the lane given by addr[1:0], then apply the extension: lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-015 The following accesses SHALL be flagged as errors:
- half with addr[0]=1;
- word with addr[1:0]!=0;
- funct3 in {011, 110, 111};
- store funct3 greater than 010.
REQ-016 A flagged access SHALL still receive gnt, SHALL skip ACCESS (mem_en stays 0), and SHALL go directly to RESP with err=1 and rdata=0.
REQ-017 All rN_gnt, rN_rvalid, rN_err and rN_rdata SHALL be 0 for the non-owner and outside their qualifying cycle.
REQ-018 Without round-robin, arbitration SHALL be fixed priority with r0 winning over r1.

Reset
REQ-019 With rst=1 at a rising edge, the FSM SHALL go to IDLE, all outputs SHALL be 0 on the following cycle, and the round-robin pointer SHALL be set to "r1 last granted".
REQ-020 Reset during ACCESS or RESP SHALL abandon the access: no rvalid is issued for it and mem_en deasserts the next cycle.

Configuration
REQ-021 When DMEM_ARB_RR_EN is defined, arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins, and the pointer updates on every gnt.
REQ-022 When DMEM_ARB_RR_EN is undefined, the block SHALL use the fixed priority of REQ-018 and the pointer register SHALL not exist.

Structure
REQ-023 A shared package dmem_pkg SHALL hold:
- the funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW);
- the FSM state enum (IDLE, ACCESS, RESP);
- the owner ID typedef.
REQ-024 Byte-enable generation, write steering and load extraction/extension SHALL live in the combinational sub-module dmem_lane_fmt.

Verification
REQ-025 The bench SHALL cover: r0 lb at addr 0x103, mem_rdata=0x80FF_0000, mem_ready=1 -> mem_be=1000, r0_rdata=0xFFFF_FF80 at cycle 2.
REQ-026 The bench SHALL cover: r1 sh at 0x22, wdata=0x0000_ABCD, with 2 wait states -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_en held 3 cycles, r1_rvalid at cycle 4.
REQ-027 The bench SHALL cover: r0 lw at 0x101 -> r0_gnt, no mem_en, r0_rvalid=1 with r0_err=1 and r0_rdata=0 at cycle 1.
REQ-028 The bench SHALL cover: r0 and r1 requesting continuously for 4 grants -> fixed priority gives r0 all four; with DMEM_ARB_RR_EN the order is r0, r1, r0, r1.
REQ-029 The bench SHALL cover: rst asserted in the second ACCESS cycle of a wait-stated load -> no rvalid, mem_en=0 the next cycle, and a new request is granted after rst drops.
REQ-030 The bench SHALL cover: r1 lhu at 0x2 with mem_rdata=0x8001_0000 -> r1_rdata=0x0000_8001.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and access legality check for the data-memory arbiter.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic {OWN_R0, OWN_R1} owner_t;

    // Misaligned halves/words, reserved width codes and unsigned-store codes are illegal.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            LB, LBU: bad = 1'b0;
            LH, LHU: bad = addr_lo[0];
            LW:      bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        if (we && (funct3 > SW)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
interface dmem_arbiter_if;

    logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
    logic [2:0]  r0_funct3;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;

    logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
    logic [2:0]  r1_funct3;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;

    logic        mem_en, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_funct3, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_funct3, r1_addr, r1_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output r0_req, r0_we, r0_funct3, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_funct3, r1_addr, r1_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-enable generation, write-lane replication and load extraction/extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        be         = '0;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = '0;
        endcase

        case (funct3)
            LB:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            LH:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     rdata_ext = {24'h0, shifted[7:0]};
            LHU:     rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one access outstanding (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority r0 > r1.
module dmem_arbiter
    import dmem_pkg::*;
(
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    state_t      state;
    owner_t      owner;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, data_q;

    logic        grant, pick_r1, win_we, win_err;
    logic [2:0]  win_f3;
    logic [31:0] win_addr, win_wdata;
    logic [3:0]  be;
    logic [31:0] wdata_lane, rdata_ext;
    logic        mem_active, resp0, resp1;

`ifdef DMEM_ARB_RR_EN
    logic last_r1;

    always_ff @(posedge clk) begin
        if (rst) last_r1 <= 1'b1;
        else if (grant) last_r1 <= pick_r1;
    end

    assign pick_r1 = bus.r1_req && (!bus.r0_req || !last_r1);
`else
    assign pick_r1 = bus.r1_req && !bus.r0_req;
`endif

    // Grant is decided combinationally in the IDLE cycle so gnt lands in cycle 0.
    always_comb begin
        grant     = (state == IDLE) && !rst && (bus.r0_req || bus.r1_req);
        win_we    = pick_r1 ? bus.r1_we     : bus.r0_we;
        win_f3    = pick_r1 ? bus.r1_funct3 : bus.r0_funct3;
        win_addr  = pick_r1 ? bus.r1_addr   : bus.r0_addr;
        win_wdata = pick_r1 ? bus.r1_wdata  : bus.r0_wdata;
        win_err   = access_err(win_we, win_f3, win_addr[1:0]);
    end

    dmem_lane_fmt u_lane_fmt (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (bus.mem_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_R0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner   <= pick_r1 ? OWN_R1 : OWN_R0;
                        we_q    <= win_we;
                        f3_q    <= win_f3;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        err_q   <= win_err;
                        data_q  <= '0;
                        state   <= win_err ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        data_q <= we_q ? '0 : rdata_ext;
                        state  <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_active    = (state == ACCESS);
    assign resp0         = (state == RESP) && (owner == OWN_R0);
    assign resp1         = (state == RESP) && (owner == OWN_R1);

    assign bus.mem_en    = mem_active;
    assign bus.mem_we    = mem_active && we_q;
    assign bus.mem_be    = mem_active ? be : '0;
    assign bus.mem_addr  = mem_active ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_wdata = (mem_active && we_q) ? wdata_lane : '0;

    assign bus.r0_gnt    = grant && !pick_r1;
    assign bus.r1_gnt    = grant && pick_r1;
    assign bus.r0_rvalid = resp0;
    assign bus.r1_rvalid = resp1;
    assign bus.r0_err    = resp0 && err_q;
    assign bus.r1_err    = resp1 && err_q;
    assign bus.r0_rdata  = resp0 ? data_q : '0;
    assign bus.r1_rdata  = resp1 ? data_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (works with or without DMEM_ARB_RR_EN).
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_funct3 = '0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_funct3 = '0; bus.r1_addr = '0; bus.r1_wdata = '0;
    endtask

    task automatic drive_req(input int unsigned who, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (who == 0) begin
            bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_funct3 = f3;
            bus.r0_addr = addr; bus.r0_wdata = wdata;
        end else begin
            bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_funct3 = f3;
            bus.r1_addr = addr; bus.r1_wdata = wdata;
        end
    endtask

    initial begin
        logic [3:0] order;
        logic [3:0] exp_order;
        int unsigned ngr;

        rst = 1'b1;
        clear_reqs();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.r0_req = 1'b1;
        bus.r1_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_r0_gnt",    32'(bus.r0_gnt), 0);
        check_eq("rst_r1_gnt",    32'(bus.r1_gnt), 0);
        check_eq("rst_mem_en",    32'(bus.mem_en), 0);
        check_eq("rst_mem_be",    32'(bus.mem_be), 0);
        check_eq("rst_r0_rvalid", 32'(bus.r0_rvalid), 0);
        check_eq("rst_r1_rdata",  bus.r1_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();

        // r0 lb at 0x103, no wait states
        @(negedge clk);
        drive_req(0, 1'b0, LB, 32'h103, 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h80FF_0000;
        #1;
        check_eq("lb_c0_r0_gnt", 32'(bus.r0_gnt), 1);
        check_eq("lb_c0_r1_gnt", 32'(bus.r1_gnt), 0);
        check_eq("lb_c0_mem_en", 32'(bus.mem_en), 0);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("lb_c1_mem_en",   32'(bus.mem_en), 1);
        check_eq("lb_c1_mem_be",   32'(bus.mem_be), 32'h8);
        check_eq("lb_c1_mem_addr", bus.mem_addr, 32'h100);
        check_eq("lb_c1_mem_we",   32'(bus.mem_we), 0);
        check_eq("lb_c1_rvalid",   32'(bus.r0_rvalid), 0);
        @(negedge clk);
        #1;
        check_eq("lb_c2_rvalid",    32'(bus.r0_rvalid), 1);
        check_eq("lb_c2_rdata",     bus.r0_rdata, 32'hFFFF_FF80);
        check_eq("lb_c2_err",       32'(bus.r0_err), 0);
        check_eq("lb_c2_r1_rvalid", 32'(bus.r1_rvalid), 0);
        check_eq("lb_c2_mem_en",    32'(bus.mem_en), 0);
        @(negedge clk);
        #1;
        check_eq("lb_c3_rvalid", 32'(bus.r0_rvalid), 0);
        check_eq("lb_c3_rdata",  bus.r0_rdata, 0);

        // r1 sh at 0x22, two wait states
        @(negedge clk);
        drive_req(1, 1'b1, SH, 32'h22, 32'h0000_ABCD);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("sh_c0_r1_gnt", 32'(bus.r1_gnt), 1);
        check_eq("sh_c0_r0_gnt", 32'(bus.r0_gnt), 0);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("sh_c1_mem_en",    32'(bus.mem_en), 1);
        check_eq("sh_c1_mem_we",    32'(bus.mem_we), 1);
        check_eq("sh_c1_mem_be",    32'(bus.mem_be), 32'hC);
        check_eq("sh_c1_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        check_eq("sh_c1_mem_addr",  bus.mem_addr, 32'h20);
        @(negedge clk);
        #1;
        check_eq("sh_c2_mem_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check_eq("sh_c3_mem_en", 32'(bus.mem_en), 1);
        check_eq("sh_c3_rvalid", 32'(bus.r1_rvalid), 0);
        @(negedge clk);
        #1;
        check_eq("sh_c4_rvalid",    32'(bus.r1_rvalid), 1);
        check_eq("sh_c4_rdata",     bus.r1_rdata, 0);
        check_eq("sh_c4_err",       32'(bus.r1_err), 0);
        check_eq("sh_c4_r0_rvalid", 32'(bus.r0_rvalid), 0);
        check_eq("sh_c4_mem_en",    32'(bus.mem_en), 0);

        // r0 lw at 0x101: misaligned, skips ACCESS
        @(negedge clk);
        drive_req(0, 1'b0, LW, 32'h101, 32'h0);
        bus.mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("lwerr_c0_gnt", 32'(bus.r0_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("lwerr_c1_mem_en", 32'(bus.mem_en), 0);
        check_eq("lwerr_c1_rvalid", 32'(bus.r0_rvalid), 1);
        check_eq("lwerr_c1_err",    32'(bus.r0_err), 1);
        check_eq("lwerr_c1_rdata",  bus.r0_rdata, 0);
        @(negedge clk);
        #1;
        check_eq("lwerr_c2_rvalid", 32'(bus.r0_rvalid), 0);
        check_eq("lwerr_c2_err",    32'(bus.r0_err), 0);

        // r0 store with funct3=100 is illegal
        @(negedge clk);
        drive_req(0, 1'b1, LBU, 32'h10, 32'h55);
        #1;
        check_eq("sbad_c0_gnt", 32'(bus.r0_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("sbad_c1_mem_en", 32'(bus.mem_en), 0);
        check_eq("sbad_c1_err",    32'(bus.r0_err), 1);

        // r1 lhu at 0x2
        @(negedge clk);
        drive_req(1, 1'b0, LHU, 32'h2, 32'h0);
        bus.mem_rdata = 32'h8001_0000;
        #1;
        check_eq("lhu_c0_gnt", 32'(bus.r1_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("lhu_c1_mem_be", 32'(bus.mem_be), 32'hC);
        @(negedge clk);
        #1;
        check_eq("lhu_c2_rvalid",   32'(bus.r1_rvalid), 1);
        check_eq("lhu_c2_rdata",    bus.r1_rdata, 32'h0000_8001);
        check_eq("lhu_c2_r0_rdata", bus.r0_rdata, 0);

        // r1 sw at 0x8: store returns rdata=0 even with live mem_rdata
        @(negedge clk);
        drive_req(1, 1'b1, SW, 32'h8, 32'h1234_5678);
        #1;
        check_eq("sw_c0_gnt", 32'(bus.r1_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("sw_c1_mem_be",    32'(bus.mem_be), 32'hF);
        check_eq("sw_c1_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        check_eq("sw_c1_mem_addr",  bus.mem_addr, 32'h8);
        @(negedge clk);
        #1;
        check_eq("sw_c2_rvalid", 32'(bus.r1_rvalid), 1);
        check_eq("sw_c2_rdata",  bus.r1_rdata, 0);

        // both requesters continuously for four grants
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        order = '0;
        ngr   = 0;
        @(negedge clk);
        drive_req(0, 1'b0, LW, 32'h0, 32'h0);
        drive_req(1, 1'b0, LW, 32'h4, 32'h0);
        for (int c = 0; c < 24 && ngr < 4; c++) begin
            #1;
            if (bus.r0_gnt && bus.r1_gnt) check_eq("arb_double_gnt", 32'h1, 32'h0);
            if (bus.r0_gnt || bus.r1_gnt) begin
                order[ngr[1:0]] = bus.r1_gnt;
                ngr++;
            end
            @(negedge clk);
        end
        clear_reqs();
        check_eq("arb_grant_count", ngr, 4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("arb_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        repeat (3) @(negedge clk);

        // reset during the second ACCESS cycle of a wait-stated load
        drive_req(0, 1'b0, LW, 32'h40, 32'h0);
        bus.mem_ready = 1'b0;
        #1;
        check_eq("rst_acc_c0_gnt", 32'(bus.r0_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("rst_acc_c1_mem_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_acc_c2_mem_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check_eq("rst_acc_c3_mem_en", 32'(bus.mem_en), 0);
        check_eq("rst_acc_c3_rvalid", 32'(bus.r0_rvalid), 0);
        @(negedge clk);
        drive_req(1, 1'b0, LBU, 32'h1, 32'h0);
        bus.mem_rdata = 32'h0000_8F00;
        #1;
        check_eq("rst_acc_c4_rvalid", 32'(bus.r0_rvalid), 0);
        check_eq("rst_acc_c4_gnt",    32'(bus.r1_gnt), 1);
        @(negedge clk);
        clear_reqs();
        #1;
        check_eq("rst_acc_c5_mem_en", 32'(bus.mem_en), 1);
        @(negedge clk);
        #1;
        check_eq("rst_acc_c6_rvalid", 32'(bus.r1_rvalid), 1);
        check_eq("rst_acc_c6_rdata",  bus.r1_rdata, 32'h0000_008F);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
